if_debug_ctrl: RTL and testbench



---
 rtl/if_debug_ctrl.sv | 233 +++++++++++++++++++++++
 tb/tb_if_debug_ctrl.sv | 320 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/if_debug_ctrl.sv
// ---------------------------------------------------------------------------
// if_debug_ctrl
//
// Debug sequencer for the instruction-fetch stage. It loads a program into
// instruction memory from a received byte stream, then lets the pipeline
// free-run or advance one cycle at a time. It stops execution when a HALT
// word is fetched.
//
// Commands (accepted only in IDLE, except 'C' which is also accepted in HALTED):
//   'L' 0x4C  load a program, little-endian bytes, one word per INST_SZ/8 bytes
//   'R' 0x52  run until HALT is fetched
//   'S' 0x53  single step (one enabled cycle)
//   'C' 0x43  clear halt and pulse the pipeline reset
//
// Ports:
//   i_clk            clock
//   i_reset          synchronous active-high reset
//   i_rx_data        received byte
//   i_rx_valid       one-cycle strobe qualifying i_rx_data
//   i_instruction_F  instruction currently fetched by the IF stage
//   o_write          instruction memory write strobe
//   o_write_addr     byte address for the write
//   o_instruction    assembled instruction (memory write data)
//   o_enable         pipeline execution enable
//   o_pipe_reset     one-cycle pipeline clear pulse
//   o_loaded         a valid (HALT-terminated) program is in memory
//   o_halted         HALT was fetched
//   o_load_err       load filled MEM_DEPTH words without a HALT word
//   o_state          current state, for debug
//   o_cycle_count    enabled-cycle counter, saturating (only with
//                    IF_CYCLE_COUNT_EN defined)
//
// Optional feature macro: IF_CYCLE_COUNT_EN
// ---------------------------------------------------------------------------
module if_debug_ctrl #(
  parameter int INST_SZ    = 32,
  parameter int ADDR_SZ    = 32,
  parameter int MEM_DEPTH  = 64,
  parameter logic [INST_SZ-1:0] HALT_INSTR = 32'hFFFFFFFF
) (
  input  logic               i_clk,
  input  logic               i_reset,
  input  logic [7:0]         i_rx_data,
  input  logic               i_rx_valid,
  input  logic [INST_SZ-1:0] i_instruction_F,
  output logic               o_write,
  output logic [ADDR_SZ-1:0] o_write_addr,
  output logic [INST_SZ-1:0] o_instruction,
  output logic               o_enable,
  output logic               o_pipe_reset,
  output logic               o_loaded,
  output logic               o_halted,
  output logic               o_load_err,
  output logic [2:0]         o_state
`ifdef IF_CYCLE_COUNT_EN
  ,
  output logic [31:0]        o_cycle_count
`endif
);

  localparam int NB  = INST_SZ / 8;
  localparam int BCW = (NB > 1) ? $clog2(NB) : 1;
  localparam logic [BCW-1:0]     LAST_BYTE = BCW'(NB - 1);
  localparam logic [ADDR_SZ-1:0] LAST_ADDR = ADDR_SZ'((MEM_DEPTH - 1) * 4);

  localparam logic [7:0] CMD_L = 8'h4C;
  localparam logic [7:0] CMD_R = 8'h52;
  localparam logic [7:0] CMD_S = 8'h53;
  localparam logic [7:0] CMD_C = 8'h43;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    LOAD   = 3'd1,
    WRITE  = 3'd2,
    RUN    = 3'd3,
    STEP   = 3'd4,
    HALTED = 3'd5
  } state_t;

  state_t               state_q, state_d;
  logic [BCW-1:0]       byte_cnt_q, byte_cnt_d;
  logic [ADDR_SZ-1:0]   addr_q, addr_d;
  logic [INST_SZ-1:0]   instr_q, instr_d;
  logic                 pipe_reset_q, pipe_reset_d;
  logic                 loaded_q, loaded_d;
  logic                 halted_q, halted_d;
  logic                 load_err_q, load_err_d;

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      state_q      <= IDLE;
      byte_cnt_q   <= '0;
      addr_q       <= '0;
      instr_q      <= '0;
      pipe_reset_q <= 1'b0;
      loaded_q     <= 1'b0;
      halted_q     <= 1'b0;
      load_err_q   <= 1'b0;
    end else begin
      state_q      <= state_d;
      byte_cnt_q   <= byte_cnt_d;
      addr_q       <= addr_d;
      instr_q      <= instr_d;
      pipe_reset_q <= pipe_reset_d;
      loaded_q     <= loaded_d;
      halted_q     <= halted_d;
      load_err_q   <= load_err_d;
    end
  end

  always_comb begin
    state_d      = state_q;
    byte_cnt_d   = byte_cnt_q;
    addr_d       = addr_q;
    instr_d      = instr_q;
    pipe_reset_d = 1'b0;
    loaded_d     = loaded_q;
    halted_d     = halted_q;
    load_err_d   = load_err_q;

    case (state_q)
      IDLE: begin
        if (i_rx_valid) begin
          case (i_rx_data)
            CMD_L: begin
              state_d    = LOAD;
              loaded_d   = 1'b0;
              load_err_d = 1'b0;
              halted_d   = 1'b0;
              addr_d     = '0;
              byte_cnt_d = '0;
            end
            CMD_R: if (loaded_q && !halted_q) state_d = RUN;
            CMD_S: if (loaded_q && !halted_q) state_d = STEP;
            CMD_C: begin
              pipe_reset_d = 1'b1;
              halted_d     = 1'b0;
            end
            default: ;
          endcase
        end
      end

      LOAD: begin
        if (i_rx_valid) begin
          // Little-endian assembly: byte k lands in bits [8k+7:8k].
          for (int b = 0; b < NB; b++) begin
            if (byte_cnt_q == BCW'(b)) instr_d[b*8 +: 8] = i_rx_data;
          end
          if (byte_cnt_q == LAST_BYTE) begin
            byte_cnt_d = '0;
            state_d    = WRITE;
          end else begin
            byte_cnt_d = byte_cnt_q + 1'b1;
          end
        end
      end

      WRITE: begin
        // The address advances after every write, including the final one,
        // so after an overflow it points one past the last word (no wrap).
        addr_d = addr_q + ADDR_SZ'(4);
        if (instr_q == HALT_INSTR) begin
          loaded_d = 1'b1;
          state_d  = IDLE;
        end else if (addr_q == LAST_ADDR) begin
          load_err_d = 1'b1;
          loaded_d   = 1'b0;
          state_d    = IDLE;
        end else begin
          state_d = LOAD;
        end
      end

      RUN: begin
        if (i_instruction_F == HALT_INSTR) begin
          halted_d = 1'b1;
          state_d  = HALTED;
        end
      end

      STEP: begin
        if (i_instruction_F == HALT_INSTR) begin
          halted_d = 1'b1;
          state_d  = HALTED;
        end else begin
          state_d = IDLE;
        end
      end

      HALTED: begin
        if (i_rx_valid && (i_rx_data == CMD_C)) begin
          pipe_reset_d = 1'b1;
          halted_d     = 1'b0;
          state_d      = IDLE;
        end
      end

      default: state_d = IDLE;
    endcase
  end

  // Write and enable decode from disjoint states, so they can never overlap.
  assign o_write       = (state_q == WRITE);
  assign o_enable      = (state_q == RUN) || (state_q == STEP);
  assign o_write_addr  = addr_q;
  assign o_instruction = instr_q;
  assign o_pipe_reset  = pipe_reset_q;
  assign o_loaded      = loaded_q;
  assign o_halted      = halted_q;
  assign o_load_err    = load_err_q;
  assign o_state       = state_q;

`ifdef IF_CYCLE_COUNT_EN
  logic [31:0] cycle_cnt_q;
  logic        cnt_clr;

  // Same acceptance condition as the 'C' command in the FSM.
  assign cnt_clr = i_rx_valid && (i_rx_data == CMD_C) &&
                   ((state_q == IDLE) || (state_q == HALTED));

  always_ff @(posedge i_clk) begin
    if (i_reset || cnt_clr) begin
      cycle_cnt_q <= '0;
    end else if (o_enable && (cycle_cnt_q != 32'hFFFFFFFF)) begin
      cycle_cnt_q <= cycle_cnt_q + 32'd1;
    end
  end

  assign o_cycle_count = cycle_cnt_q;
`endif

endmodule

// File: tb/tb_if_debug_ctrl.sv
module tb_if_debug_ctrl;

  localparam int MD = 4;
  localparam logic [31:0] HALT = 32'hFFFFFFFF;

  logic        clk = 1'b0;
  logic        rst;
  logic [7:0]  rx_data;
  logic        rx_valid;
  logic [31:0] instr_f;
  logic        o_write;
  logic [31:0] o_write_addr;
  logic [31:0] o_instruction;
  logic        o_enable;
  logic        o_pipe_reset;
  logic        o_loaded;
  logic        o_halted;
  logic        o_load_err;
  logic [2:0]  o_state;
`ifdef IF_CYCLE_COUNT_EN
  logic [31:0] o_cycle_count;
`endif

  if_debug_ctrl #(
    .INST_SZ   (32),
    .ADDR_SZ   (32),
    .MEM_DEPTH (MD),
    .HALT_INSTR(HALT)
  ) dut (
    .i_clk          (clk),
    .i_reset        (rst),
    .i_rx_data      (rx_data),
    .i_rx_valid     (rx_valid),
    .i_instruction_F(instr_f),
    .o_write        (o_write),
    .o_write_addr   (o_write_addr),
    .o_instruction  (o_instruction),
    .o_enable       (o_enable),
    .o_pipe_reset   (o_pipe_reset),
    .o_loaded       (o_loaded),
    .o_halted       (o_halted),
    .o_load_err     (o_load_err),
    .o_state        (o_state)
`ifdef IF_CYCLE_COUNT_EN
    ,
    .o_cycle_count  (o_cycle_count)
`endif
  );

  always #5 clk = ~clk;

  int n_vec = 0;
  int n_err = 0;

  task automatic chk_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end
  endtask

  // Monitor: records memory writes, counts enabled cycles and clear pulses.
  logic        mon_en = 1'b0;
  int          en_cnt = 0;
  int          pr_cnt = 0;
  logic [31:0] wa_q[$];
  logic [31:0] wd_q[$];

  always @(negedge clk) begin
    if (mon_en) begin
      if (o_write) begin
        wa_q.push_back(o_write_addr);
        wd_q.push_back(o_instruction);
      end
      if (o_enable) en_cnt++;
      if (o_pipe_reset) pr_cnt++;
      chk_eq("excl_write_enable", {63'b0, o_write & o_enable}, 64'd0);
    end
  end

  // Behavioural reference: program-level status flags and enabled-cycle total.
  logic        m_loaded, m_halted, m_err;
  int          m_cnt;
  logic [31:0] prog[$];

  function automatic logic [31:0] nonhalt();
    logic [31:0] w;
    w = $urandom;
    if (w == HALT) w = 32'd0;
    return w;
  endfunction

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic send(input logic [7:0] b);
    rx_data  = b;
    rx_valid = 1'b1;
    @(posedge clk);
    #1;
    rx_valid = 1'b0;
  endtask

  task automatic chk_status(input logic [2:0] st);
    chk_eq("state",    {61'b0, o_state}, {61'b0, st});
    chk_eq("loaded",   {63'b0, o_loaded}, {63'b0, m_loaded});
    chk_eq("halted",   {63'b0, o_halted}, {63'b0, m_halted});
    chk_eq("load_err", {63'b0, o_load_err}, {63'b0, m_err});
    chk_eq("enable",   {63'b0, o_enable}, {63'b0, (st == 3'd3) || (st == 3'd4)});
`ifdef IF_CYCLE_COUNT_EN
    if (st == 3'd0 || st == 3'd5) chk_eq("cycle_count", {32'b0, o_cycle_count}, 64'(m_cnt));
`endif
  endtask

  task automatic do_reset(input bit with_byte);
    rst = 1'b1;
    if (with_byte) begin
      rx_data  = 8'h4C;
      rx_valid = 1'b1;
    end
    @(posedge clk);
    #1;
    rst      = 1'b0;
    rx_valid = 1'b0;
    m_loaded = 1'b0;
    m_halted = 1'b0;
    m_err    = 1'b0;
    m_cnt    = 0;
    chk_status(3'd0);
    chk_eq("rst_write", {63'b0, o_write}, 64'd0);
    chk_eq("rst_addr",  {32'b0, o_write_addr}, 64'd0);
    chk_eq("rst_instr", {32'b0, o_instruction}, 64'd0);
    chk_eq("rst_prst",  {63'b0, o_pipe_reset}, 64'd0);
  endtask

  // A byte that must not change anything in the current state.
  task automatic try_ignored(input logic [7:0] b, input logic [2:0] st);
    int e0;
    e0 = en_cnt;
    send(b);
    chk_status(st);
    tick(1);
    chk_status(st);
    chk_eq("ignored_no_enable", 64'(en_cnt - e0), 64'd0);
  endtask

  task automatic load_prog();
    int          nw;
    bit          done;
    logic [31:0] w;
    wa_q.delete();
    wd_q.delete();
    send(8'h4C);
    m_loaded = 1'b0;
    m_err    = 1'b0;
    m_halted = 1'b0;
    chk_status(3'd1);
    chk_eq("load_addr0", {32'b0, o_write_addr}, 64'd0);
    nw   = 0;
    done = 1'b0;
    for (int i = 0; i < prog.size() && !done; i++) begin
      w = prog[i];
      for (int b = 0; b < 4; b++) begin
        repeat ($urandom_range(0, 2)) begin
          rx_data = 8'($urandom);
          tick(1);
        end
        send(w[8*b +: 8]);
      end
      chk_eq("write_strobe", {63'b0, o_write}, 64'd1);
      tick(1);
      nw++;
      if (w == HALT) begin
        m_loaded = 1'b1;
        done = 1'b1;
      end else if (i == MD - 1) begin
        m_err = 1'b1;
        done = 1'b1;
      end
    end
    chk_eq("n_writes", 64'(wa_q.size()), 64'(nw));
    for (int i = 0; i < nw && i < wa_q.size(); i++) begin
      chk_eq("wr_addr", {32'b0, wa_q[i]}, 64'(4 * i));
      chk_eq("wr_data", {32'b0, wd_q[i]}, {32'b0, prog[i]});
    end
    chk_eq("end_addr", {32'b0, o_write_addr}, 64'(4 * nw));
    chk_status(done ? 3'd0 : 3'd1);
  endtask

  task automatic run_prog(input int n);
    int         e0;
    logic [7:0] ign[4];
    ign = '{8'h52, 8'h53, 8'h4C, 8'h7A};
    e0 = en_cnt;
    instr_f = nonhalt();
    send(8'h52);
    chk_status(3'd3);
    repeat (n) begin
      instr_f = nonhalt();
      tick(1);
      chk_eq("run_hold_enable", {63'b0, o_enable}, 64'd1);
    end
    instr_f = HALT;
    tick(1);
    instr_f  = 32'd0;
    m_halted = 1'b1;
    m_cnt    = m_cnt + n + 1;
    chk_eq("run_cycles", 64'(en_cnt - e0), 64'(n + 1));
    chk_status(3'd5);
    try_ignored(ign[$urandom_range(0, 3)], 3'd5);
  endtask

  task automatic step_once(input bit h);
    int e0;
    e0 = en_cnt;
    instr_f = h ? HALT : nonhalt();
    send(8'h53);
    chk_status(3'd4);
    tick(1);
    instr_f = 32'd0;
    m_cnt++;
    if (h) m_halted = 1'b1;
    chk_eq("step_pulse", 64'(en_cnt - e0), 64'd1);
    chk_status(h ? 3'd5 : 3'd0);
  endtask

  task automatic clear();
    int p0;
    p0 = pr_cnt;
    send(8'h43);
    m_halted = 1'b0;
    m_cnt    = 0;
    chk_eq("prst_on", {63'b0, o_pipe_reset}, 64'd1);
    chk_status(3'd0);
    tick(1);
    chk_eq("prst_off", {63'b0, o_pipe_reset}, 64'd0);
    chk_eq("prst_pulses", 64'(pr_cnt - p0), 64'd1);
  endtask

  initial begin
    int k;
    bit hl;
    rst      = 1'b0;
    rx_valid = 1'b0;
    rx_data  = 8'h00;
    instr_f  = 32'd0;

    do_reset(1'b0);
    mon_en = 1'b1;

    // Illegal commands before any program exists.
    try_ignored(8'h52, 3'd0);
    try_ignored(8'h7A, 3'd0);
    try_ignored(8'h53, 3'd0);

    // Directed load, run to HALT, clear.
    prog = {32'h00000001, HALT};
    load_prog();
    run_prog(5);
    clear();

    // Three single steps, clear keeps the program, then a step onto HALT.
    step_once(1'b0);
    step_once(1'b0);
    step_once(1'b0);
    clear();
    step_once(1'b1);
    clear();

    // Overflow: MD words without HALT.
    prog.delete();
    repeat (MD) prog.push_back(nonhalt());
    load_prog();
    try_ignored(8'h52, 3'd0);
    try_ignored(8'h53, 3'd0);

    // Mid-load reset, with a command byte arriving together with reset.
    send(8'h4C);
    send(8'h12);
    send(8'h34);
    do_reset(1'b1);
    prog = {HALT};
    load_prog();

    // Randomized programs and operations.
    repeat (25) begin
      k  = $urandom_range(1, MD);
      hl = (k < MD) ? 1'b1 : 1'($urandom_range(0, 1));
      prog.delete();
      for (int i = 0; i < k - 1; i++) prog.push_back(nonhalt());
      prog.push_back(hl ? HALT : nonhalt());
      load_prog();
      if (m_loaded) begin
        case ($urandom_range(0, 2))
          0: begin
            run_prog($urandom_range(0, 12));
            clear();
          end
          1: begin
            repeat ($urandom_range(1, 3)) step_once(1'b0);
            if ($urandom_range(0, 1) == 1) step_once(1'b1);
            clear();
          end
          default: do_reset(1'b0);
        endcase
      end else begin
        try_ignored(8'h52, 3'd0);
      end
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
